// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: byte FIFO fed by DATA stores, drained by a serial shifter.
// Registers: DATA, STATUS, DIVISOR, reserved, decoded from DwAddress[3:2] within a 16-byte window.
module uart_tx_mmio #(
    parameter logic [31:0] BASE_ADDR   = 32'hFF200100,
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        DwReadEnable,
    input  logic        DwWriteEnable,
    input  logic [3:0]  DwByteEnable,
    input  logic [31:0] DwAddress,
    input  logic [31:0] DwWriteData,
    output logic [31:0] oReadData,
    output logic        oSelected,
    output logic        oTX,
    output logic        oBusy
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               ovf_q, ovf_d;
    logic [15:0]        div_q, div_d;
    logic [15:0]        period_q, period_d;
    logic [15:0]        cnt_q, cnt_d;
    logic [2:0]         bit_q, bit_d;
    logic [7:0]         shift_q, shift_d;
    logic               tx_q, tx_d;
    logic [7:0]         mem_q [FIFO_DEPTH];

    logic        sel, wr_en, full, empty, push_req, push, pop, last;
    logic [1:0]  reg_off;
    logic [31:0] rdata;
    logic        unused_ok;

    assign sel       = (DwAddress[31:4] == BASE_ADDR[31:4]);
    assign reg_off   = DwAddress[3:2];
    assign wr_en     = sel && DwWriteEnable;
    assign full      = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty     = (count_q == '0);
    assign push_req  = wr_en && (reg_off == 2'd0) && DwByteEnable[0];
    assign push      = push_req && !full;
    assign pop       = (state_q == S_IDLE) && !empty;
    assign last      = (cnt_q == period_q - 16'd1);
    assign unused_ok = ^{DwReadEnable, DwAddress[1:0], DwByteEnable[3:2], DwWriteData[31:16]};

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        div_d    = div_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        // A dropped push wins over a clear; both cannot target the same register anyway.
        if (push_req && full)
            ovf_d = 1'b1;
        else if (wr_en && reg_off == 2'd1 && DwByteEnable[0] && DwWriteData[3])
            ovf_d = 1'b0;
        if (wr_en && reg_off == 2'd2) begin
            if (DwByteEnable[0]) div_d[7:0]  = DwWriteData[7:0];
            if (DwByteEnable[1]) div_d[15:8] = DwWriteData[15:8];
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        period_d = period_q;
        tx_d     = tx_q;
        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (pop) begin
                    state_d  = S_START;
                    shift_d  = mem_q[rd_ptr_q];
                    period_d = (div_q == 16'd0) ? 16'd1 : div_q;
                    cnt_d    = '0;
                    bit_d    = '0;
                    tx_d     = 1'b0;
                end
            end
            S_START: begin
                if (last) begin
                    state_d = S_DATA;
                    cnt_d   = '0;
                    tx_d    = shift_q[0];
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_DATA: begin
                if (last) begin
                    cnt_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_STOP: begin
                if (last) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            div_q    <= DEFAULT_DIV;
            period_q <= 16'd1;
            cnt_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            div_q    <= div_d;
            period_q <= period_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
        end
    end

    always_ff @(posedge iCLK) begin
        if (push) mem_q[wr_ptr_q] <= DwWriteData[7:0];
    end

    always_comb begin
        rdata = '0;
        if (sel) begin
            case (reg_off)
                2'd1: begin
                    rdata[0]    = (state_q != S_IDLE);
                    rdata[1]    = full;
                    rdata[2]    = empty;
                    rdata[3]    = ovf_q;
                    rdata[15:8] = 8'(count_q);
                end
                2'd2:    rdata[15:0] = div_q;
                default: rdata = '0;
            endcase
        end
    end

    assign oReadData = rdata;
    assign oSelected = sel;
    assign oTX       = tx_q;
    assign oBusy     = (state_q != S_IDLE) || !empty;

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed bench for uart_tx_mmio: frame timing, FIFO full/overflow, divisor lanes, reset, decode.
module tb_uart_tx_mmio;

    localparam logic [31:0] BASE   = 32'hFF200100;
    localparam logic [31:0] A_DATA = BASE;
    localparam logic [31:0] A_STAT = BASE + 32'd4;
    localparam logic [31:0] A_DIV  = BASE + 32'd8;
    localparam logic [31:0] A_RSV  = BASE + 32'd12;

    logic        iCLK, iRST;
    logic        DwReadEnable, DwWriteEnable;
    logic [3:0]  DwByteEnable;
    logic [31:0] DwAddress, DwWriteData;
    logic [31:0] oReadData;
    logic        oSelected, oTX, oBusy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    uart_tx_mmio #(.BASE_ADDR(32'hFF200100), .FIFO_DEPTH(16), .DEFAULT_DIV(16'd434)) dut (
        .iCLK(iCLK), .iRST(iRST), .DwReadEnable(DwReadEnable), .DwWriteEnable(DwWriteEnable),
        .DwByteEnable(DwByteEnable), .DwAddress(DwAddress), .DwWriteData(DwWriteData),
        .oReadData(oReadData), .oSelected(oSelected), .oTX(oTX), .oBusy(oBusy)
    );

    initial begin
        iCLK = 1'b0;
        forever #5 iCLK = ~iCLK;
    end

    always @(posedge iCLK) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge iCLK);
            #1;
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        DwAddress = a; DwWriteData = d; DwByteEnable = be;
        DwWriteEnable = 1'b1; DwReadEnable = 1'b0;
        @(posedge iCLK);
        #1;
        DwWriteEnable = 1'b0; DwByteEnable = 4'b0000;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        DwAddress = a; DwReadEnable = 1'b1; DwWriteEnable = 1'b0;
        #1;
        d = oReadData;
        DwReadEnable = 1'b0;
    endtask

    // Captures one frame of period p; k=1 is the first cycle oTX is low.
    task automatic rx_frame(input int p, output logic [7:0] got, output int start_cyc,
                            output bit found, output bit shape_ok, output bit busy_ok);
        logic tx;
        int   b;
        got = '0; start_cyc = 0; shape_ok = 1'b1; busy_ok = 1'b1;
        DwAddress = A_STAT; DwReadEnable = 1'b1; DwWriteEnable = 1'b0;
        #1;
        for (int w = 0; w < 200 && oTX !== 1'b0; w++) begin
            @(posedge iCLK);
            #1;
        end
        found = (oTX === 1'b0);
        if (found) begin
            start_cyc = cyc;
            for (int k = 1; k <= 10 * p; k++) begin
                if (k > 1) begin
                    @(posedge iCLK);
                    #1;
                end
                tx = oTX;
                if (oReadData[0] !== 1'b1) busy_ok = 1'b0;
                if (k <= p) begin
                    if (tx !== 1'b0) shape_ok = 1'b0;
                end else if (k <= 9 * p) begin
                    b = (k - 1) / p - 1;
                    if ((k - 1) % p == 0) got[b] = tx;
                    else if (tx !== got[b]) shape_ok = 1'b0;
                end else begin
                    if (tx !== 1'b1) shape_ok = 1'b0;
                end
            end
        end
        DwReadEnable = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        iRST = 1'b1; DwReadEnable = 1'b0; DwWriteEnable = 1'b0;
        DwByteEnable = 4'b0000; DwAddress = '0; DwWriteData = '0;
        tick(2);
        iRST = 1'b0;
        checks++; if (oTX !== 1'b1) begin errors++; $display("FAIL reset_tx got %b exp 1", oTX); end
        checks++; if (oBusy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", oBusy); end
        bus_read(A_STAT, rd);
        checks++; if (rd !== 32'h4) begin errors++; $display("FAIL reset_status got %h exp 00000004", rd); end
        checks++; if (oSelected !== 1'b1) begin errors++; $display("FAIL reset_sel got %b exp 1", oSelected); end
        bus_read(A_DIV, rd);
        checks++; if (rd !== 32'd434) begin errors++; $display("FAIL reset_div got %0d exp 434", rd); end
        tick(1);
        bus_read(A_DATA, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL data_read got %h exp 0", rd); end
        bus_read(A_RSV, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rsv_read got %h exp 0", rd); end
        tick(1);
    endtask

    task automatic test_single_frame();
        logic [31:0] rd;
        logic [7:0]  got;
        int          w, st;
        bit          found, shape_ok, busy_ok;
        bus_write(A_DIV, 32'h0000_0004, 4'b0011);
        bus_read(A_DIV, rd);
        checks++; if (rd !== 32'h4) begin errors++; $display("FAIL t1_div got %h exp 4", rd); end
        bus_write(A_DATA, 32'h0000_0055, 4'b0001);
        w = cyc;
        checks++; if (oTX !== 1'b1) begin errors++; $display("FAIL t1_tx_prepop got %b exp 1", oTX); end
        checks++; if (oBusy !== 1'b1) begin errors++; $display("FAIL t1_busy_prepop got %b exp 1", oBusy); end
        rx_frame(4, got, st, found, shape_ok, busy_ok);
        checks++; if (!found) begin errors++; $display("FAIL t1_found got timeout exp start"); end
        checks++; if (st !== w + 1) begin errors++; $display("FAIL t1_latency got %0d exp %0d", st - w, 1); end
        checks++; if (got !== 8'h55) begin errors++; $display("FAIL t1_byte got %h exp 55", got); end
        checks++; if (!shape_ok) begin errors++; $display("FAIL t1_shape got bad exp 8N1"); end
        checks++; if (!busy_ok) begin errors++; $display("FAIL t1_status_busy got 0 exp 1"); end
        tick(1);
        checks++; if (cyc - w !== 41) begin errors++; $display("FAIL t1_idle_time got %0d exp 41", cyc - w); end
        checks++; if (oBusy !== 1'b0) begin errors++; $display("FAIL t1_idle_busy got %b exp 0", oBusy); end
        checks++; if (oTX !== 1'b1) begin errors++; $display("FAIL t1_idle_tx got %b exp 1", oTX); end
    endtask

    task automatic test_overflow_and_drain();
        logic [31:0] rd;
        logic [7:0]  got;
        int          w1, st, prev;
        bit          found, shape_ok, busy_ok;
        for (int i = 0; i < 18; i++) begin
            bus_write(A_DATA, 32'(i), 4'b0001);
            if (i == 0) w1 = cyc;
        end
        bus_read(A_STAT, rd);
        checks++; if (rd !== 32'h0000_100B) begin errors++; $display("FAIL t2_full got %h exp 0000100b", rd); end
        checks++; if (oBusy !== 1'b1) begin errors++; $display("FAIL t2_busy got %b exp 1", oBusy); end
        bus_write(A_STAT, 32'h0000_0000, 4'b0001);
        bus_read(A_STAT, rd);
        checks++; if (rd !== 32'h0000_100B) begin errors++; $display("FAIL t2_noclr_bit got %h exp 0000100b", rd); end
        bus_write(A_STAT, 32'h0000_0008, 4'b0000);
        bus_read(A_STAT, rd);
        checks++; if (rd !== 32'h0000_100B) begin errors++; $display("FAIL t2_noclr_lane got %h exp 0000100b", rd); end
        bus_write(A_STAT, 32'h0000_0008, 4'b0001);
        bus_read(A_STAT, rd);
        checks++; if (rd !== 32'h0000_1003) begin errors++; $display("FAIL t2_clr got %h exp 00001003", rd); end
        // Push on the very edge that pops 0x01: full was sampled, so it must drop.
        for (int w = 0; w < 100 && cyc < w1 + 41; w++) tick(1);
        checks++; if (cyc !== w1 + 41) begin errors++; $display("FAIL t2_align got %0d exp %0d", cyc - w1, 41); end
        bus_write(A_DATA, 32'h0000_00EE, 4'b0001);
        bus_read(A_STAT, rd);
        checks++; if (rd !== 32'h0000_0F09) begin errors++; $display("FAIL t2_pop_push got %h exp 00000f09", rd); end
        prev = w1 + 1;
        for (int i = 1; i <= 16; i++) begin
            rx_frame(4, got, st, found, shape_ok, busy_ok);
            checks++; if (!found) begin errors++; $display("FAIL t3_found%0d got timeout exp start", i); end
            checks++; if (got !== 8'(i)) begin errors++; $display("FAIL t3_byte%0d got %h exp %h", i, got, 8'(i)); end
            checks++; if (!shape_ok || !busy_ok) begin errors++; $display("FAIL t3_shape%0d got %b%b exp 11", i, shape_ok, busy_ok); end
            checks++; if (st - prev !== 41) begin errors++; $display("FAIL t3_gap%0d got %0d exp 41", i, st - prev); end
            prev = st;
        end
        tick(1);
        checks++; if (oBusy !== 1'b0) begin errors++; $display("FAIL t3_busy got %b exp 0", oBusy); end
        bus_read(A_STAT, rd);
        checks++; if (rd !== 32'h0000_000C) begin errors++; $display("FAIL t3_status got %h exp 0000000c", rd); end
        bus_write(A_STAT, 32'h0000_0008, 4'b0001);
        bus_read(A_STAT, rd);
        checks++; if (rd !== 32'h0000_0004) begin errors++; $display("FAIL t3_final got %h exp 00000004", rd); end
    endtask

    task automatic test_div_zero_and_lanes();
        logic [31:0] rd;
        logic [7:0]  got;
        int          w, st;
        bit          found, shape_ok, busy_ok;
        bus_write(A_DIV, 32'h0000_0000, 4'b0011);
        bus_write(A_DATA, 32'h0000_00A3, 4'b0001);
        w = cyc;
        // Lands on the popping edge; the period for this frame is already fixed.
        bus_write(A_DIV, 32'h0000_0003, 4'b0011);
        rx_frame(1, got, st, found, shape_ok, busy_ok);
        checks++; if (!found) begin errors++; $display("FAIL t4_found got timeout exp start"); end
        checks++; if (st !== w + 1) begin errors++; $display("FAIL t4_latency got %0d exp 1", st - w); end
        checks++; if (got !== 8'hA3) begin errors++; $display("FAIL t4_byte got %h exp a3", got); end
        checks++; if (!shape_ok) begin errors++; $display("FAIL t4_shape got bad exp 8N1"); end
        tick(1);
        checks++; if (cyc - w !== 11 || oBusy !== 1'b0) begin errors++; $display("FAIL t4_len got %0d/%b exp 11/0", cyc - w, oBusy); end
        bus_read(A_DIV, rd);
        checks++; if (rd !== 32'h3) begin errors++; $display("FAIL t4_div got %h exp 3", rd); end
        bus_write(A_DIV, 32'hFFFF_FF56, 4'b0001);
        bus_read(A_DIV, rd);
        checks++; if (rd !== 32'h0000_0056) begin errors++; $display("FAIL t4_lane0 got %h exp 00000056", rd); end
        bus_write(A_DIV, 32'hFFFF_12FF, 4'b0010);
        bus_read(A_DIV, rd);
        checks++; if (rd !== 32'h0000_1256) begin errors++; $display("FAIL t4_lane1 got %h exp 00001256", rd); end
    endtask

    task automatic test_mid_frame_reset();
        logic [31:0] rd;
        bit          idle_ok;
        bus_write(A_DIV, 32'h0000_0004, 4'b0011);
        bus_write(A_DATA, 32'h0000_00F0, 4'b0001);
        bus_write(A_DATA, 32'h0000_000F, 4'b0001);
        tick(8);
        checks++; if (oTX !== 1'b0) begin errors++; $display("FAIL t5_pre got %b exp 0", oTX); end
        iRST = 1'b1;
        tick(1);
        iRST = 1'b0;
        checks++; if (oTX !== 1'b1) begin errors++; $display("FAIL t5_tx got %b exp 1", oTX); end
        checks++; if (oBusy !== 1'b0) begin errors++; $display("FAIL t5_busy got %b exp 0", oBusy); end
        bus_read(A_STAT, rd);
        checks++; if (rd !== 32'h0000_0004) begin errors++; $display("FAIL t5_status got %h exp 00000004", rd); end
        bus_read(A_DIV, rd);
        checks++; if (rd !== 32'd434) begin errors++; $display("FAIL t5_div got %0d exp 434", rd); end
        idle_ok = 1'b1;
        for (int i = 0; i < 60; i++) begin
            tick(1);
            if (oTX !== 1'b1 || oBusy !== 1'b0) idle_ok = 1'b0;
        end
        checks++; if (!idle_ok) begin errors++; $display("FAIL t5_residual got activity exp idle"); end
    endtask

    task automatic test_decode();
        logic [31:0] rd;
        bus_read(BASE + 32'h10, rd);
        checks++; if (oSelected !== 1'b0 || rd !== 32'h0) begin errors++; $display("FAIL t6_above got %b/%h exp 0/0", oSelected, rd); end
        bus_read(BASE - 32'h4, rd);
        checks++; if (oSelected !== 1'b0 || rd !== 32'h0) begin errors++; $display("FAIL t6_below got %b/%h exp 0/0", oSelected, rd); end
        bus_read(BASE + 32'hF, rd);
        checks++; if (oSelected !== 1'b1) begin errors++; $display("FAIL t6_top_sel got %b exp 1", oSelected); end
        tick(1);
        bus_write(BASE + 32'h10, 32'h0000_0077, 4'b1111);
        bus_write(BASE + 32'h18, 32'h0000_1234, 4'b1111);
        bus_write(A_RSV, 32'hFFFF_FFFF, 4'b1111);
        tick(3);
        checks++; if (oTX !== 1'b1 || oBusy !== 1'b0) begin errors++; $display("FAIL t6_idle got %b/%b exp 1/0", oTX, oBusy); end
        bus_read(A_STAT, rd);
        checks++; if (rd !== 32'h0000_0004) begin errors++; $display("FAIL t6_status got %h exp 00000004", rd); end
        bus_read(A_DIV, rd);
        checks++; if (rd !== 32'd434) begin errors++; $display("FAIL t6_div got %0d exp 434", rd); end
        bus_read(A_RSV, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL t6_rsv got %h exp 0", rd); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_overflow_and_drain();
        test_div_zero_and_lanes();
        test_mid_frame_reset();
        test_decode();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
